// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the dual-clock FIFO pointer blocks.
//   FIFO_SYNC_STAGES_DEF : default depth of a pointer synchroniser
//   bin2gray(b, w)       : binary -> gray for a w-bit value (w <= 32)
//   gray2bin(g, w)       : gray -> binary for a w-bit value (w <= 32)
// Both converters work on 32-bit containers so that any pointer width can
// call them; callers size-cast the result back to their own width.
package fifo_pkg;

    localparam int FIFO_SYNC_STAGES_DEF = 2;

    // Mask that keeps only the low w bits of a 32-bit container.
    function automatic logic [31:0] width_mask(input int w);
        if (w >= 32)
            return '1;
        else
            return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int w);
        return (b ^ (b >> 1)) & width_mask(w);
    endfunction

    // Each binary bit is the XOR of all gray bits at or above it; the
    // doubling shifts build that running XOR in log2(32) steps.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] b;
        b = g & width_mask(w);
        for (int s = 1; s < 32; s = s * 2)
            b = b ^ (b >> s);
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_sync_if.sv
// rptr_empty_sync_if
// Bundles the read-side request/flag signals of the FIFO read pointer block.
//   master : the reader (drives rinc, rclr_uf, ae_thresh) plus the write
//            pointer feed rwptr; observes address, pointer and flags
//   slave  : the rptr_empty_sync block itself
interface rptr_empty_sync_if #(parameter int ADDRSIZE = 4);

    logic                rinc;
    logic                rclr_uf;
    logic [ADDRSIZE:0]   ae_thresh;
    logic [ADDRSIZE:0]   rwptr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                ralmost_empty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;

    modport master (
        output rinc, rclr_uf, ae_thresh, rwptr,
        input  raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
    );

    modport slave (
        input  rinc, rclr_uf, ae_thresh, rwptr,
        output raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
    );

endinterface

// File: rtl/sync_nff.sv
// sync_nff
// Generic N-flop synchroniser for a vector that is already glitch-safe to
// sample (e.g. a gray-coded pointer).
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input vector
//   q     : last stage of the chain
module sync_nff #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the sampled value one stage per clock; stage 0 is the only flop
    // that may go metastable, later stages give it time to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++)
                chain[i] <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++)
                chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rptr_empty_sync.sv
// rptr_empty_sync
// Read-domain half of the dual-clock FIFO: read pointer, empty flag,
// fill level, almost-empty flag and sticky underflow flag.
//   rclk   : read clock
//   rrst_n : asynchronous active-low reset
//   rif    : slave side of rptr_empty_sync_if
//            in : rinc, rclr_uf, ae_thresh, rwptr (write gray pointer,
//                 asynchronous to rclk)
//            out: raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
module rptr_empty_sync
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = FIFO_SYNC_STAGES_DEF
) (
    input  logic                    rclk,
    input  logic                    rrst_n,
    rptr_empty_sync_if.slave        rif
);

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] rwptr_s;
    logic [PW-1:0] wbin_s;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbnext;
    logic [PW-1:0] rgnext;
    logic [PW-1:0] lvl_next;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] rlevel_q;
    logic          rempty_q;
    logic          rae_q;
    logic          ruf_q;
    logic          rd_ok;
    logic          uf_set;

    // Bring the write gray pointer into the read clock domain.
    sync_nff #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (rif.rwptr),
        .q     (rwptr_s)
    );

    // Next-pointer arithmetic. A read is only taken while not empty, so an
    // attempted read on an empty FIFO leaves the pointer untouched and is
    // reported as an underflow instead. The level subtraction wraps mod
    // 2^PW, which keeps it correct when either pointer's MSB has toggled.
    always_comb begin
        rd_ok    = rif.rinc & ~rempty_q;
        uf_set   = rif.rinc & rempty_q;
        wbin_s   = PW'(gray2bin(32'(rwptr_s), PW));
        rbnext   = rbin + PW'(rd_ok);
        rgnext   = PW'(bin2gray(32'(rbnext), PW));
        lvl_next = wbin_s - rbnext;
    end

    // Pointer and flag registers. Everything is computed from the
    // post-read pointer so a read and its flag update land on the same edge.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin     <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            rlevel_q <= '0;
            rae_q    <= 1'b1;
        end else begin
            rbin     <= rbnext;
            rptr_q   <= rgnext;
            rempty_q <= (rgnext == rwptr_s);
            rlevel_q <= lvl_next;
            rae_q    <= (lvl_next <= rif.ae_thresh);
        end
    end

    // Sticky underflow flag; a new underflow takes priority over a clear
    // arriving in the same cycle so no event is ever lost.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)
            ruf_q <= 1'b0;
        else if (uf_set)
            ruf_q <= 1'b1;
        else if (rif.rclr_uf)
            ruf_q <= 1'b0;
    end

    assign rif.raddr         = rbin[ADDRSIZE-1:0];
    assign rif.rptr          = rptr_q;
    assign rif.rempty        = rempty_q;
    assign rif.ralmost_empty = rae_q;
    assign rif.rlevel        = rlevel_q;
    assign rif.runderflow    = ruf_q;

endmodule

// File: tb/tb_rptr_empty_sync.sv
// tb_rptr_empty_sync
// Self-checking bench for rptr_empty_sync (ADDRSIZE=4, SYNC_STAGES=2).
// A directed vector table covers fill/drain, almost-empty and underflow;
// randomized streaming is compared against a count-based occupancy model.
module tb_rptr_empty_sync;

    localparam int AW   = 4;
    localparam int SYNC = 2;
    localparam int PW   = AW + 1;

    logic rclk;
    logic rrst_n;

    rptr_empty_sync_if #(.ADDRSIZE(AW)) bus ();

    rptr_empty_sync #(
        .ADDRSIZE    (AW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rif    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // Reference model state: counts of words written / read (unbounded
    // integers), the write counts seen by the read side, and flags.
    int wcnt;
    int rcnt;
    int samp[$];
    int m_level;
    bit m_empty;
    bit m_ae;
    bit m_uf;

    typedef struct {
        int   wc;
        bit   inc;
        bit   clr;
        int   exp_raddr;
        int   exp_rptr;
        int   exp_level;
        bit   exp_empty;
        bit   exp_ae;
        bit   exp_uf;
    } vec_t;

    vec_t vec[15];

    function automatic logic [PW-1:0] toGray(input int n);
        logic [PW-1:0] b;
        b = PW'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic resetModel();
        wcnt    = 0;
        rcnt    = 0;
        samp    = {};
        for (int i = 0; i < SYNC; i++) samp.push_back(0);
        m_level = 0;
        m_empty = 1'b1;
        m_ae    = 1'b1;
        m_uf    = 1'b0;
    endtask

    task automatic applyStimulus(input int wc, input bit inc, input bit clr, input int thr);
        wcnt          = wc;
        bus.rwptr     = toGray(wc);
        bus.rinc      = inc;
        bus.rclr_uf   = clr;
        bus.ae_thresh = PW'(thr);
    endtask

    // Advance the model by one read-clock edge: the write count becomes
    // visible SYNC edges after it was sampled.
    task automatic modelEdge();
        int  wsync;
        bit  acc;
        wsync = samp.pop_front();
        samp.push_back(wcnt);
        acc = bus.rinc && !m_empty;
        if (bus.rinc && m_empty) m_uf = 1'b1;
        else if (bus.rclr_uf)    m_uf = 1'b0;
        if (acc) rcnt++;
        m_level = wsync - rcnt;
        m_empty = (m_level == 0);
        m_ae    = (m_level <= int'(bus.ae_thresh));
    endtask

    task automatic tick();
        @(posedge rclk);
        if (rrst_n) modelEdge();
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rempty"},  int'(bus.rempty), 1);
        checkOutput({tag, "_ae"},      int'(bus.ralmost_empty), 1);
        checkOutput({tag, "_rlevel"},  int'(bus.rlevel), 0);
        checkOutput({tag, "_rptr"},    int'(bus.rptr), 0);
        checkOutput({tag, "_raddr"},   int'(bus.raddr), 0);
        checkOutput({tag, "_uf"},      int'(bus.runderflow), 0);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_rlevel"}, int'(bus.rlevel), m_level);
        checkOutput({tag, "_rempty"}, int'(bus.rempty), int'(m_empty));
        checkOutput({tag, "_ae"},     int'(bus.ralmost_empty), int'(m_ae));
        checkOutput({tag, "_uf"},     int'(bus.runderflow), int'(m_uf));
        checkOutput({tag, "_rptr"},   int'(bus.rptr), int'(toGray(rcnt)));
        checkOutput({tag, "_raddr"},  int'(bus.raddr), rcnt % 16);
        checkOutput({tag, "_nover"},  int'(int'(bus.rlevel) <= (wcnt - rcnt)), 1);
    endtask

    task automatic doReset();
        rrst_n = 1'b0;
        resetModel();
        applyStimulus(0, 1'b0, 1'b0, 3);
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    initial begin
        int  prevMsb;
        int  toggles;
        int  cyc;
        bit  inc;

        // Fill/drain/underflow table, ae_thresh=3, starting right after reset.
        vec[0]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0};
        vec[1]  = '{2, 0, 0, 0, 0, 0, 1, 1, 0};
        vec[2]  = '{3, 0, 0, 0, 0, 1, 0, 1, 0};
        vec[3]  = '{4, 0, 0, 0, 0, 2, 0, 1, 0};
        vec[4]  = '{5, 0, 0, 0, 0, 3, 0, 1, 0};
        vec[5]  = '{5, 0, 0, 0, 0, 4, 0, 0, 0};
        vec[6]  = '{5, 0, 0, 0, 0, 5, 0, 0, 0};
        vec[7]  = '{5, 1, 0, 1, 1, 4, 0, 0, 0};
        vec[8]  = '{5, 1, 0, 2, 3, 3, 0, 1, 0};
        vec[9]  = '{5, 1, 0, 3, 2, 2, 0, 1, 0};
        vec[10] = '{5, 1, 0, 4, 6, 1, 0, 1, 0};
        vec[11] = '{5, 1, 0, 5, 7, 0, 1, 1, 0};
        vec[12] = '{5, 1, 0, 5, 7, 0, 1, 1, 1};
        vec[13] = '{5, 1, 1, 5, 7, 0, 1, 1, 1};
        vec[14] = '{5, 0, 1, 5, 7, 0, 0 == 0, 1, 0};

        // Reset held while the write pointer toggles.
        rrst_n = 1'b0;
        resetModel();
        applyStimulus(0, 1'b0, 1'b0, 3);
        #2;
        for (int i = 1; i <= 4; i++) begin
            bus.rwptr = toGray(i * 3);
            bus.rinc  = i[0];
            tick();
        end
        checkReset("rst_hold");
        bus.rwptr = '0;
        bus.rinc  = 1'b0;
        tick();
        rrst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vec[i].wc, vec[i].inc, vec[i].clr, 3);
            tick();
            checkOutput($sformatf("vec%0d_raddr", i), int'(bus.raddr), vec[i].exp_raddr);
            checkOutput($sformatf("vec%0d_rptr", i),  int'(bus.rptr), vec[i].exp_rptr);
            checkOutput($sformatf("vec%0d_rlevel", i), int'(bus.rlevel), vec[i].exp_level);
            checkOutput($sformatf("vec%0d_rempty", i), int'(bus.rempty), int'(vec[i].exp_empty));
            checkOutput($sformatf("vec%0d_ae", i), int'(bus.ralmost_empty), int'(vec[i].exp_ae));
            checkOutput($sformatf("vec%0d_uf", i), int'(bus.runderflow), int'(vec[i].exp_uf));
        end

        // Single write into an empty FIFO: rempty falls on the third edge.
        doReset();
        applyStimulus(1, 1'b0, 1'b0, 0);
        tick();
        checkOutput("lat_e1", int'(bus.rempty), 1);
        tick();
        checkOutput("lat_e2", int'(bus.rempty), 1);
        tick();
        checkOutput("lat_e3", int'(bus.rempty), 0);
        checkOutput("lat_lvl", int'(bus.rlevel), 1);

        // Randomized stream of 40 words through the wrap points.
        doReset();
        prevMsb = 0;
        toggles = 0;
        cyc     = 0;
        while (rcnt < 40 && cyc < 2000) begin
            int wc;
            wc  = wcnt;
            if (wc < 40 && (wc - rcnt) < 16 && $urandom_range(0, 3) != 0) wc++;
            inc = (rcnt < 40) && ($urandom_range(0, 1) == 1);
            applyStimulus(wc, inc, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 18)));
            tick();
            checkModel("rnd");
            if (int'(bus.rptr[AW]) != prevMsb) toggles++;
            prevMsb = int'(bus.rptr[AW]);
            cyc++;
        end
        checkOutput("rnd_done", rcnt, 40);
        checkOutput("rnd_msb_toggles", toggles, 2);

        // Build level 6, then assert reset between edges.
        doReset();
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(i, 1'b0, 1'b0, 3);
            tick();
        end
        for (int i = 0; i < 3; i++) tick();
        checkOutput("mid_level", int'(bus.rlevel), 6);
        checkModel("mid");
        #1;
        rrst_n = 1'b0;
        #1;
        checkReset("rst_async");
        resetModel();
        applyStimulus(0, 1'b0, 1'b0, 3);
        tick();
        rrst_n = 1'b1;
        tick();
        checkModel("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rptr_empty_sync.md
# rptr_empty_sync

Read-side pointer and flag block for the dual-clock FIFO. It generalises the basic gray-pointer/empty logic with several additions: a built-in write-pointer synchroniser of parametrised depth, a registered fill level, a programmable almost-empty flag and a sticky underflow flag. It sits entirely in the read clock domain, drives the memory read address, and returns its gray pointer to the write side.

## Interface
- `ADDRSIZE`, 4: memory address width; FIFO depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `SYNC_STAGES`, 2: flops in the write-pointer synchroniser; legal range 2..4.

- `rclk`  in  1  read-domain clock.
- `rrst_n`  in  1  asynchronous, active-low reset.
- `rinc`  in  1  read request; consumes one word when `rempty`=0.
- `rclr_uf`  in  1  clears `runderflow`.
- `ae_thresh`  in  ADDRSIZE+1  almost-empty threshold, in words.
- `rwptr`  in  ADDRSIZE+1  write gray pointer; asynchronous to `rclk`.
- `raddr`  out  ADDRSIZE  memory read address = `rbin[ADDRSIZE-1:0]`.
- `rptr`  out  ADDRSIZE+1  registered read gray pointer, sent to the write side.
- `rempty`  out  1  FIFO empty.
- `ralmost_empty`  out  1  level ≤ `ae_thresh`.
- `rlevel`  out  ADDRSIZE+1  words available to read, 0..2^ADDRSIZE.
- `runderflow`  out  1  sticky: a read was attempted while empty.

## Operation
- Synchroniser: `rwptr` passes through a SYNC_STAGES-deep flop chain; its last stage is `rwptr_s`.
- Binary conversion: `wbin_s` = gray2bin(`rwptr_s`), combinational.
- Next read pointer: `rbnext` = `rbin` + (`rinc` & !`rempty`). `rgnext` = `rbnext` ^ (`rbnext`>>1).
- Registered each edge:
  - `rbin`<=`rbnext`
  - `rptr`<=`rgnext`
  - `rempty`<=(`rgnext`==`rwptr_s`)
  - `rlevel`<=`wbin_s`-`rbnext`, arithmetic mod 2^(ADDRSIZE+1)
  - `ralmost_empty`<=(`wbin_s`-`rbnext`) ≤ `ae_thresh`, unsigned compare
- Underflow: `rinc`=1 while `rempty`=1 leaves the pointer unchanged and sets `runderflow` on the next edge. `rclr_uf` clears the flag. If a set and a clear occur in the same cycle, set wins.
- Wrap-around: the pointer MSB toggles every 2^ADDRSIZE reads. The level math stays correct across the wrap because of the modulo subtraction.
- `ae_thresh`=0 makes `ralmost_empty` equal to `rempty`. `ae_thresh` ≥ 2^ADDRSIZE holds `ralmost_empty` at 1.
- Reset (async assert, released on an `rclk` edge): all synchroniser flops, `rbin` and `rptr` go to 0; `rempty`=1, `ralmost_empty`=1, `rlevel`=0, `runderflow`=0. Reset asserted mid-operation discards all state immediately.

## Timing
- A write-pointer change reaches `rempty`, `rlevel` and `ralmost_empty` on the (SYNC_STAGES+1)th `rclk` edge after it is sampled.
- An accepted read updates `raddr`, `rptr`, `rempty`, `rlevel` and `ralmost_empty` at the next edge. Consecutive reads are accepted every cycle.
- `rempty` is pessimistic: it may stay 1 for up to SYNC_STAGES+1 cycles after data is written. It is never 0 while the FIFO is truly empty.
- `rlevel` is an under-estimate of the true occupancy by the write-side sync latency. It never over-estimates.
- Data at `raddr` is valid whenever `rempty`=0. The memory read is combinational or registered by the RAM wrapper.
- `rwptr` must change by one gray step per `wclk`. This block does not check that.

## Structure
- Shared package `fifo_pkg`:
  - functions `bin2gray` and `gray2bin`, parametrised by width
  - constant `FIFO_SYNC_STAGES_DEF`=2
- Sub-module `sync_nff`: a generic N-flop synchroniser, vector width parameter, async active-low reset. It is reused by the write side.
- Everything else is a single module.

## Test plan
- Reset: hold `rrst_n`=0 and toggle `rwptr` → `rempty`=1, `ralmost_empty`=1, `rlevel`=0, `rptr`=0, `raddr`=0, `runderflow`=0.
- Fill then drain (ADDRSIZE=4, SYNC_STAGES=2): step `rwptr` gray 0→5 → `rempty` falls 3 edges after the final step and `rlevel`=5; 5 back-to-back `rinc` → `raddr` 0..4, then `rempty`=1 and `rlevel`=0.
- Almost-empty: `ae_thresh`=3, level 8, read one per cycle → `ralmost_empty` rises when `rlevel` becomes 3, not at 4.
- Underflow: `rempty`=1, `rinc`=1 for one cycle → `rbin` unchanged and `runderflow`=1. With `rinc` and `rclr_uf` both asserted while empty → flag stays 1. `rclr_uf` alone → 0.
- Wrap: stream 40 words through with the write side kept 1–16 ahead → `rptr` MSB toggles at 16 and 32, `rlevel` never exceeds 16 and never goes negative, `rempty` is correct at every step.
- Reset mid-stream: assert `rrst_n`=0 with level 6 → all outputs return to reset values asynchronously, before the next `rclk` edge.
